// File: rtl/active_vertex_writeback_pkg.sv
// Shared widths, FSM encoding and error-flag positions for the active-vertex write-back tail.
// Optional feature macro used by this block: WB_UPDATE_COUNT_EN.
package active_vertex_writeback_pkg;

    localparam int unsigned V_ID_WIDTH_DEF      = 20;
    localparam int unsigned ITERATION_WIDTH_DEF = 8;
    localparam int unsigned CORE_NUM_WIDTH_DEF  = 5;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StEndHold = 2'd2
    } wb_state_e;

    localparam int unsigned ErrOverflow     = 0;
    localparam int unsigned ErrStaleEnd     = 1;
    localparam int unsigned ErrCoreMismatch = 2;

endpackage

// File: rtl/active_vertex_writeback_if.sv
// Apply-side, frontend-side and bitmap write-back signals of the write-back tail.
// The updated_count signal exists only when WB_UPDATE_COUNT_EN is defined.
interface active_vertex_writeback_if #(
    parameter int unsigned V_ID_WIDTH      = active_vertex_writeback_pkg::V_ID_WIDTH_DEF,
    parameter int unsigned ITERATION_WIDTH = active_vertex_writeback_pkg::ITERATION_WIDTH_DEF
);
    logic [V_ID_WIDTH-1:0]      apply_v_id;
    logic                       apply_v_updated;
    logic                       apply_v_valid;
    logic                       apply_iteration_end;
    logic                       apply_iteration_end_valid;
    logic [ITERATION_WIDTH-1:0] apply_iteration_id;
    logic [ITERATION_WIDTH-1:0] frontend_iteration_id;
    logic                       frontend_iteration_done;
    logic                       apply_stage_full;
    logic [V_ID_WIDTH-1:0]      backend_active_v_id;
    logic                       backend_active_v_updated;
    logic                       backend_active_v_id_valid;
    logic                       backend_iteration_end;
    logic                       backend_iteration_end_valid;
    logic [ITERATION_WIDTH-1:0] backend_iteration_id;
    logic [2:0]                 err_flags;
`ifdef WB_UPDATE_COUNT_EN
    logic [V_ID_WIDTH-1:0]      updated_count;
`endif

    modport slave (
        input  apply_v_id, apply_v_updated, apply_v_valid,
        input  apply_iteration_end, apply_iteration_end_valid, apply_iteration_id,
        input  frontend_iteration_id, frontend_iteration_done,
`ifdef WB_UPDATE_COUNT_EN
        output updated_count,
`endif
        output apply_stage_full,
        output backend_active_v_id, backend_active_v_updated, backend_active_v_id_valid,
        output backend_iteration_end, backend_iteration_end_valid, backend_iteration_id,
        output err_flags
    );

    modport master (
        output apply_v_id, apply_v_updated, apply_v_valid,
        output apply_iteration_end, apply_iteration_end_valid, apply_iteration_id,
        output frontend_iteration_id, frontend_iteration_done,
`ifdef WB_UPDATE_COUNT_EN
        input  updated_count,
`endif
        input  apply_stage_full,
        input  backend_active_v_id, backend_active_v_updated, backend_active_v_id_valid,
        input  backend_iteration_end, backend_iteration_end_valid, backend_iteration_id,
        input  err_flags
    );

endinterface

// File: rtl/active_vertex_writeback_result_fifo.sv
// wb_result_fifo: synchronous FIFO with occupancy count, async active-low reset and sync flush.
// Push while full and pop while empty are ignored.
module wb_result_fifo #(
    parameter int unsigned WIDTH       = 21,
    parameter int unsigned DEPTH_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [DEPTH_WIDTH:0]   count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned Depth = 1 << DEPTH_WIDTH;

    logic [WIDTH-1:0]       mem_q [Depth];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   count_q, count_d;
    logic                   do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (DEPTH_WIDTH + 1)'(Depth));
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
            count_d = count_q + (DEPTH_WIDTH + 1)'(do_push) - (DEPTH_WIDTH + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/active_vertex_writeback.sv
// Per-core apply tail: queues vertex results, writes the active bitmap one entry per cycle and
// turns the in-band end marker into a held iteration-end handshake. Option: WB_UPDATE_COUNT_EN.
module active_vertex_writeback
    import active_vertex_writeback_pkg::*;
#(
    parameter int unsigned CORE_ID          = 0,
    parameter int unsigned CORE_NUM_WIDTH   = CORE_NUM_WIDTH_DEF,
    parameter int unsigned V_ID_WIDTH       = V_ID_WIDTH_DEF,
    parameter int unsigned ITERATION_WIDTH  = ITERATION_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH_WIDTH = 4,
    parameter int unsigned FULL_THRESH      = 12
) (
    input logic                        clk,
    input logic                        rst,
    active_vertex_writeback_if.slave   bus
);
    localparam int unsigned FifoW = V_ID_WIDTH + 1;
    localparam int unsigned CntW  = FIFO_DEPTH_WIDTH + 1;

    wb_state_e                  state_q, state_d;
    logic [ITERATION_WIDTH-1:0] cur_iter_q, cur_iter_d;
    logic [V_ID_WIDTH-1:0]      out_id_q, out_id_d;
    logic                       out_upd_q, out_upd_d;
    logic                       out_valid_q, out_valid_d;
    logic                       end_q, end_d;
    logic                       full_q, full_d;
    logic [2:0]                 err_q, err_d;

    logic [FifoW-1:0] fifo_rdata;
    logic [CntW-1:0]  fifo_count, count_next;
    logic             fifo_empty, fifo_full;
    logic             flush, core_ok, marker, push, pop;

    assign flush   = bus.frontend_iteration_done;
    assign core_ok = (bus.apply_v_id[CORE_NUM_WIDTH-1:0] == CORE_NUM_WIDTH'(CORE_ID));
    assign marker  = bus.apply_iteration_end && bus.apply_iteration_end_valid;
    assign push    = bus.apply_v_valid && core_ok && !fifo_full && !flush;
    assign pop     = (state_q != StEndHold) && !fifo_empty && !flush;

    wb_result_fifo #(
        .WIDTH       (FifoW),
        .DEPTH_WIDTH (FIFO_DEPTH_WIDTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.apply_v_id, bus.apply_v_updated}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        cur_iter_d  = cur_iter_q;
        err_d       = err_q;
        out_valid_d = pop;
        out_id_d    = pop ? fifo_rdata[FifoW-1:1] : out_id_q;
        out_upd_d   = pop ? fifo_rdata[0] : out_upd_q;
        count_next  = fifo_count + CntW'(push) - CntW'(pop);

        if (bus.apply_v_valid && !flush) begin
            if (!core_ok)       err_d[ErrCoreMismatch] = 1'b1;
            else if (fifo_full) err_d[ErrOverflow]     = 1'b1;
        end

        unique case (state_q)
            StRun: begin
                if (marker) begin
                    if (bus.apply_iteration_id == cur_iter_q) state_d = StDrain;
                    else                                      err_d[ErrStaleEnd] = 1'b1;
                end
            end
            // Wait until the last popped entry has also left the output register.
            StDrain: begin
                if (fifo_empty && !out_valid_q) state_d = StEndHold;
            end
            StEndHold: begin
                if (bus.frontend_iteration_id != cur_iter_q) begin
                    cur_iter_d = cur_iter_q + ITERATION_WIDTH'(1);
                    state_d    = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (flush) begin
            state_d     = StRun;
            cur_iter_d  = bus.frontend_iteration_id;
            out_valid_d = 1'b0;
            count_next  = '0;
        end

        end_d  = (state_d == StEndHold);
        full_d = (count_next >= CntW'(FULL_THRESH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            cur_iter_q  <= '0;
            out_id_q    <= '0;
            out_upd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            end_q       <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_iter_q  <= cur_iter_d;
            out_id_q    <= out_id_d;
            out_upd_q   <= out_upd_d;
            out_valid_q <= out_valid_d;
            end_q       <= end_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

`ifdef WB_UPDATE_COUNT_EN
    logic [V_ID_WIDTH-1:0] upd_cnt_q, upd_cnt_d;

    always_comb begin
        upd_cnt_d = upd_cnt_q;
        if (state_q == StEndHold && state_d == StRun) upd_cnt_d = '0;
        else if (pop && fifo_rdata[0])               upd_cnt_d = upd_cnt_q + V_ID_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) upd_cnt_q <= '0;
        else      upd_cnt_q <= upd_cnt_d;
    end

    assign bus.updated_count = upd_cnt_q;
`endif

    assign bus.apply_stage_full            = full_q;
    assign bus.backend_active_v_id         = out_id_q;
    assign bus.backend_active_v_updated    = out_upd_q;
    assign bus.backend_active_v_id_valid   = out_valid_q;
    assign bus.backend_iteration_end       = end_q;
    assign bus.backend_iteration_end_valid = end_q;
    assign bus.backend_iteration_id        = cur_iter_q;
    assign bus.err_flags                   = err_q;

endmodule

// File: tb/tb_active_vertex_writeback.sv
// Directed bench for active_vertex_writeback with CORE_ID=3; each task drives one scenario
// and compares outputs against hand-derived values.
module tb_active_vertex_writeback;

    localparam int unsigned VW = 20;
    localparam int unsigned IW = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    active_vertex_writeback_if #(.V_ID_WIDTH(VW), .ITERATION_WIDTH(IW)) bus ();

    active_vertex_writeback #(
        .CORE_ID          (3),
        .CORE_NUM_WIDTH   (5),
        .V_ID_WIDTH       (VW),
        .ITERATION_WIDTH  (IW),
        .FIFO_DEPTH_WIDTH (4),
        .FULL_THRESH      (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.apply_v_id                = '0;
        bus.apply_v_updated           = 1'b0;
        bus.apply_v_valid             = 1'b0;
        bus.apply_iteration_end       = 1'b0;
        bus.apply_iteration_end_valid = 1'b0;
        bus.apply_iteration_id        = '0;
        bus.frontend_iteration_done   = 1'b0;
    endtask

    task automatic send_marker(input logic [IW-1:0] id);
        bus.apply_iteration_end       = 1'b1;
        bus.apply_iteration_end_valid = 1'b1;
        bus.apply_iteration_id        = id;
        tick();
        bus.apply_iteration_end       = 1'b0;
        bus.apply_iteration_end_valid = 1'b0;
    endtask

    task automatic wait_end_hold(input string name);
        int n = 0;
        while (!bus.backend_iteration_end && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.backend_iteration_end !== 1'b1) begin
            errors++;
            $display("FAIL %s_reach_end: got %b expected 1", name, bus.backend_iteration_end);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.frontend_iteration_id = '0;
        repeat (2) tick();
        checks++;
        if (bus.backend_active_v_id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", bus.backend_active_v_id_valid);
        end
        checks++;
        if (bus.backend_active_v_id !== '0) begin
            errors++; $display("FAIL reset_vid: got %0d expected 0", bus.backend_active_v_id);
        end
        checks++;
        if ({bus.backend_iteration_end, bus.backend_iteration_end_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_end: got %b%b expected 00",
                               bus.backend_iteration_end, bus.backend_iteration_end_valid);
        end
        checks++;
        if (bus.backend_iteration_id !== '0) begin
            errors++; $display("FAIL reset_iter: got %0d expected 0", bus.backend_iteration_id);
        end
        checks++;
        if ({bus.apply_stage_full, bus.err_flags} !== 4'b0000) begin
            errors++; $display("FAIL reset_full_err: got %b%b expected 0000",
                               bus.apply_stage_full, bus.err_flags);
        end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_stream();
        bus.apply_v_valid = 1'b1;
        bus.apply_v_id = 20'd3;  bus.apply_v_updated = 1'b1; tick();
        bus.apply_v_id = 20'd35; bus.apply_v_updated = 1'b0; tick();
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_active_v_id, bus.backend_active_v_updated}
            !== {1'b1, 20'd3, 1'b1}) begin
            errors++; $display("FAIL basic_w0: got v%b id%0d u%b expected v1 id3 u1",
                bus.backend_active_v_id_valid, bus.backend_active_v_id,
                bus.backend_active_v_updated);
        end
        bus.apply_v_id = 20'd67; bus.apply_v_updated = 1'b1; tick();
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_active_v_id, bus.backend_active_v_updated}
            !== {1'b1, 20'd35, 1'b0}) begin
            errors++; $display("FAIL basic_w1: got v%b id%0d u%b expected v1 id35 u0",
                bus.backend_active_v_id_valid, bus.backend_active_v_id,
                bus.backend_active_v_updated);
        end
        bus.apply_v_valid = 1'b0; tick();
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_active_v_id, bus.backend_active_v_updated}
            !== {1'b1, 20'd67, 1'b1}) begin
            errors++; $display("FAIL basic_w2: got v%b id%0d u%b expected v1 id67 u1",
                bus.backend_active_v_id_valid, bus.backend_active_v_id,
                bus.backend_active_v_updated);
        end
        tick();
        checks++;
        if (bus.backend_active_v_id_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got %b expected 0", bus.backend_active_v_id_valid);
        end
        checks++;
        if (bus.err_flags !== 3'b000) begin
            errors++; $display("FAIL basic_err: got %b expected 000", bus.err_flags);
        end
    endtask

    task automatic test_iteration_end();
        logic [VW-1:0] ids [5];
        logic          upds [5];
        int            wr = 0;
        int            cyc = 0;
        ids  = '{20'd3, 20'd35, 20'd67, 20'd99, 20'd131};
        upds = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.frontend_iteration_id = 8'd0;
        while (!bus.backend_iteration_end && cyc < 25) begin
            bus.apply_v_valid = (cyc < 5);
            if (cyc < 5) begin
                bus.apply_v_id      = ids[cyc];
                bus.apply_v_updated = upds[cyc];
            end
            bus.apply_iteration_end       = (cyc == 5);
            bus.apply_iteration_end_valid = (cyc == 5);
            bus.apply_iteration_id        = 8'd0;
            tick();
            if (bus.backend_active_v_id_valid) begin
                checks++;
                if (wr >= 5 || {bus.backend_active_v_id, bus.backend_active_v_updated}
                               !== {ids[wr], upds[wr]}) begin
                    errors++; $display("FAIL iter_write%0d: got id%0d u%b", wr,
                        bus.backend_active_v_id, bus.backend_active_v_updated);
                end
                wr++;
            end
            if (bus.backend_iteration_end && wr < 5) begin
                checks++; errors++;
                $display("FAIL iter_end_early: got end after %0d writes expected 5", wr);
            end
            cyc++;
        end
        idle_inputs();
        checks++;
        if (wr !== 5) begin
            errors++; $display("FAIL iter_write_count: got %0d expected 5", wr);
        end
        checks++;
        if ({bus.backend_iteration_end, bus.backend_iteration_end_valid,
             bus.backend_iteration_id} !== {2'b11, 8'd0}) begin
            errors++; $display("FAIL iter_end_assert: got %b%b id%0d expected 11 id0",
                bus.backend_iteration_end, bus.backend_iteration_end_valid,
                bus.backend_iteration_id);
        end
        repeat (3) begin
            tick();
            checks++;
            if ({bus.backend_iteration_end, bus.backend_iteration_end_valid} !== 2'b11) begin
                errors++; $display("FAIL iter_end_hold: got %b%b expected 11",
                    bus.backend_iteration_end, bus.backend_iteration_end_valid);
            end
        end
        bus.frontend_iteration_id = 8'd1;
        tick();
        checks++;
        if ({bus.backend_iteration_end, bus.backend_iteration_end_valid,
             bus.backend_iteration_id} !== {2'b00, 8'd1}) begin
            errors++; $display("FAIL iter_release: got %b%b id%0d expected 00 id1",
                bus.backend_iteration_end, bus.backend_iteration_end_valid,
                bus.backend_iteration_id);
        end
    endtask

    task automatic test_end_hold_push();
        send_marker(8'd1);
        wait_end_hold("hold_push");
        bus.apply_v_valid = 1'b1;
        bus.apply_v_id = 20'd195; bus.apply_v_updated = 1'b1; tick();
        bus.apply_v_id = 20'd227; bus.apply_v_updated = 1'b0; tick();
        bus.apply_v_valid = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (bus.backend_active_v_id_valid !== 1'b0) begin
                errors++; $display("FAIL hold_no_write: got %b expected 0",
                                   bus.backend_active_v_id_valid);
            end
        end
        bus.frontend_iteration_id = 8'd2;
        tick();
        checks++;
        if ({bus.backend_iteration_end, bus.backend_iteration_id} !== {1'b0, 8'd2}) begin
            errors++; $display("FAIL hold_release: got end%b id%0d expected end0 id2",
                bus.backend_iteration_end, bus.backend_iteration_id);
        end
        tick();
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_active_v_id, bus.backend_active_v_updated}
            !== {1'b1, 20'd195, 1'b1}) begin
            errors++; $display("FAIL hold_w0: got v%b id%0d u%b expected v1 id195 u1",
                bus.backend_active_v_id_valid, bus.backend_active_v_id,
                bus.backend_active_v_updated);
        end
        tick();
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_active_v_id, bus.backend_active_v_updated}
            !== {1'b1, 20'd227, 1'b0}) begin
            errors++; $display("FAIL hold_w1: got v%b id%0d u%b expected v1 id227 u0",
                bus.backend_active_v_id_valid, bus.backend_active_v_id,
                bus.backend_active_v_updated);
        end
        tick();
    endtask

    task automatic test_flush();
        bus.apply_v_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.apply_v_id      = 20'(259 + 32 * k);
            bus.apply_v_updated = 1'b1;
            tick();
        end
        bus.apply_v_valid           = 1'b0;
        bus.frontend_iteration_id   = 8'd0;
        bus.frontend_iteration_done = 1'b1;
        tick();
        bus.frontend_iteration_done = 1'b0;
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_iteration_id} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL flush_state: got v%b id%0d expected v0 id0",
                bus.backend_active_v_id_valid, bus.backend_iteration_id);
        end
        repeat (4) begin
            tick();
            checks++;
            if (bus.backend_active_v_id_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_write: got %b expected 0",
                                   bus.backend_active_v_id_valid);
            end
        end
        checks++;
        if (bus.err_flags !== 3'b000) begin
            errors++; $display("FAIL flush_err: got %b expected 000", bus.err_flags);
        end
    endtask

    task automatic test_errors();
        send_marker(8'd4);
        bus.apply_v_valid = 1'b1;
        bus.apply_v_id = 20'd5; bus.apply_v_updated = 1'b1;
        tick();
        bus.apply_v_valid = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if (bus.backend_active_v_id_valid !== 1'b0) begin
                errors++; $display("FAIL err_no_write: got %b expected 0",
                                   bus.backend_active_v_id_valid);
            end
        end
        checks++;
        if (bus.err_flags !== 3'b110) begin
            errors++; $display("FAIL err_flags: got %b expected 110", bus.err_flags);
        end
        checks++;
        if ({bus.backend_iteration_end, bus.backend_iteration_id} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL err_stale_ignored: got end%b id%0d expected end0 id0",
                bus.backend_iteration_end, bus.backend_iteration_id);
        end
    endtask

    task automatic test_overflow();
        int wr = 0;
        send_marker(8'd0);
        wait_end_hold("ovf");
        bus.apply_v_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            bus.apply_v_id      = 20'(3 + 32 * (k - 1));
            bus.apply_v_updated = k[0];
            tick();
            checks++;
            if (bus.apply_stage_full !== (k >= 12)) begin
                errors++; $display("FAIL ovf_full_%0d: got %b expected %b", k,
                                   bus.apply_stage_full, (k >= 12));
            end
        end
        bus.apply_v_id = 20'd515; bus.apply_v_updated = 1'b1;
        tick();
        bus.apply_v_valid = 1'b0;
        checks++;
        if ({bus.err_flags, bus.apply_stage_full} !== 4'b1111) begin
            errors++; $display("FAIL ovf_err: got err%b full%b expected err111 full1",
                bus.err_flags, bus.apply_stage_full);
        end
        bus.frontend_iteration_id = 8'd1;
        tick();
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.backend_active_v_id_valid) begin
                checks++;
                if (bus.backend_active_v_id !== 20'(3 + 32 * wr)) begin
                    errors++; $display("FAIL ovf_drain%0d: got %0d expected %0d", wr,
                                       bus.backend_active_v_id, 3 + 32 * wr);
                end
                wr++;
            end
        end
        checks++;
        if (wr !== 16) begin
            errors++; $display("FAIL ovf_drain_count: got %0d expected 16", wr);
        end
        checks++;
        if ({bus.apply_stage_full, bus.backend_iteration_id} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL ovf_after: got full%b id%0d expected full0 id1",
                bus.apply_stage_full, bus.backend_iteration_id);
        end
    endtask

    task automatic test_reset_mid_drain();
        send_marker(8'd1);
        wait_end_hold("rst_drain");
        bus.apply_v_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.apply_v_id      = 20'(643 + 32 * k);
            bus.apply_v_updated = 1'b1;
            tick();
        end
        bus.apply_v_valid = 1'b0;
        bus.frontend_iteration_id = 8'd2;
        tick();
        send_marker(8'd2);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.backend_active_v_id_valid, bus.backend_active_v_id, bus.backend_active_v_updated,
             bus.backend_iteration_end, bus.backend_iteration_end_valid,
             bus.backend_iteration_id, bus.apply_stage_full, bus.err_flags} !== '0) begin
            errors++; $display("FAIL rst_async: got v%b id%0d iter%0d err%b expected all 0",
                bus.backend_active_v_id_valid, bus.backend_active_v_id,
                bus.backend_iteration_id, bus.err_flags);
        end
        bus.frontend_iteration_id = 8'd0;
        tick();
        #2 rst = 1'b1;
        repeat (5) begin
            tick();
            checks++;
            if (bus.backend_active_v_id_valid !== 1'b0) begin
                errors++; $display("FAIL rst_no_write: got %b expected 0",
                                   bus.backend_active_v_id_valid);
            end
        end
        checks++;
        if ({bus.backend_iteration_end, bus.backend_iteration_id} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL rst_after: got end%b id%0d expected end0 id0",
                bus.backend_iteration_end, bus.backend_iteration_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_stream();
        test_iteration_end();
        test_end_hold_push();
        test_flush();
        test_errors();
        test_overflow();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
